// File: rtl/vadd_rr_sched.sv
// Round-robin controller sharing one 128-bit vector adder slice among NREQ
// requesters; each 256-bit add runs as a low pass then a high pass.
module vadd_rr_sched #(
    parameter int NREQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*256-1:0]    ina,
    input  logic [NREQ*256-1:0]    inb,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [255:0]           sum,
    output logic [15:0]            ovf_lanes,
    output logic                   ovf,
    output logic                   busy,
    output logic [127:0]           add_a,
    output logic [127:0]           add_b,
    input  logic [127:0]           add_sum,
    input  logic [7:0]             add_ovf
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   g;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   idx;
    logic [GW:0]     pos;
    logic            found;
    logic [127:0]    sum_lo;
    logic [7:0]      ovf_lo;
    logic [255:0]    opa [NREQ];
    logic [255:0]    opb [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = ina[256*i +: 256];
            opb[i] = inb[256*i +: 256];
        end
    end

    // Search ptr, ptr+1, ... wrapping at NREQ; first asserted req wins.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        pos   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = {1'b0, ptr} + (GW+1)'(i);
            if (pos >= (GW+1)'(NREQ))
                pos = pos - (GW+1)'(NREQ);
            idx = pos[GW-1:0];
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        done      = '0;
        add_a     = '0;
        add_b     = '0;
        busy      = (state != IDLE);
        if (state != IDLE)
            gnt[g] = 1'b1;
        unique case (state)
            IDLE: if (found) state_nxt = LO;
            LO: begin
                add_a     = opa[g][127:0];
                add_b     = opb[g][127:0];
                state_nxt = HI;
            end
            HI: begin
                add_a     = opa[g][255:128];
                add_b     = opb[g][255:128];
                state_nxt = DONE;
            end
            DONE: begin
                done[g]   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            g         <= '0;
            ptr       <= '0;
            sum_lo    <= '0;
            ovf_lo    <= '0;
            sum       <= '0;
            ovf_lanes <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (found) g <= pick;
                LO: begin
                    sum_lo <= add_sum;
                    ovf_lo <= add_ovf;
                end
                HI: begin
                    sum       <= {add_sum, sum_lo};
                    ovf_lanes <= {add_ovf, ovf_lo};
                end
                DONE: ptr <= (g == GW'(NREQ-1)) ? '0 : g + 1'b1;
            endcase
        end
    end

    assign ovf = |ovf_lanes;

endmodule

// File: tb/tb_vadd_rr_sched.sv
// Directed bench for vadd_rr_sched with a behavioural 8-lane adder slice.
module tb_vadd_rr_sched;

    localparam int NREQ = 4;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*256-1:0] ina;
    logic [NREQ*256-1:0] inb;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [255:0]        sum;
    logic [15:0]         ovf_lanes;
    logic                ovf;
    logic                busy;
    logic [127:0]        add_a;
    logic [127:0]        add_b;
    logic [127:0]        add_sum;
    logic [7:0]          add_ovf;

    int checks = 0;
    int errors = 0;

    vadd_rr_sched #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req(req), .ina(ina), .inb(inb),
        .gnt(gnt), .done(done), .sum(sum), .ovf_lanes(ovf_lanes),
        .ovf(ovf), .busy(busy), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .add_ovf(add_ovf)
    );

    function automatic logic [135:0] slice(input logic [127:0] a,
                                           input logic [127:0] b);
        logic [127:0] s;
        logic [7:0]   o;
        logic [15:0]  x;
        logic [15:0]  y;
        logic [15:0]  z;
        for (int l = 0; l < 8; l++) begin
            x = a[16*l +: 16];
            y = b[16*l +: 16];
            z = x + y;
            s[16*l +: 16] = z;
            o[l] = (x[15] == y[15]) && (z[15] != x[15]);
        end
        return {o, s};
    endfunction

    assign {add_ovf, add_sum} = slice(add_a, add_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [255:0] a,
                          input logic [255:0] b);
        ina[256*i +: 256] = a;
        inb[256*i +: 256] = b;
    endtask

    int op;

    initial begin
        rst = 1'b1;
        req = '1;
        ina = '0;
        inb = '0;

        // Reset held two cycles with every request asserted.
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_gnt", 256'(gnt), 256'(0));
            chk("rst_done", 256'(done), 256'(0));
            chk("rst_busy", 256'(busy), 256'(0));
            chk("rst_sum", sum, 256'(0));
            chk("rst_ovf", 256'(ovf), 256'(0));
        end
        rst = 1'b0;
        tick();
        chk("first_gnt", 256'(gnt), 256'(4'b0001));
        chk("first_busy", 256'(busy), 256'(1));
        req = '0;
        tick();
        tick();
        chk("first_done", 256'(done), 256'(4'b0001));
        tick();
        chk("first_idle", 256'(busy), 256'(0));

        // Single op, every lane overflows.
        set_op(0, {16{16'h533a}}, {16{16'h533a}});
        req = 4'b0001;
        tick();
        chk("s_gnt", 256'(gnt), 256'(4'b0001));
        chk("s_done0", 256'(done), 256'(0));
        req = '0;
        tick();
        chk("s_done1", 256'(done), 256'(0));
        tick();
        chk("s_done2", 256'(done), 256'(4'b0001));
        chk("s_sum", sum, {16{16'ha674}});
        chk("s_ovfl", 256'(ovf_lanes), 256'(16'hffff));
        chk("s_ovf", 256'(ovf), 256'(1));
        tick();
        chk("s_done3", 256'(done), 256'(0));
        chk("s_hold", sum, {16{16'ha674}});

        // Mixed halves on requester 2.
        set_op(2, {{8{16'h7fff}}, {8{16'h0001}}}, {16{16'h0001}});
        req = 4'b0100;
        tick();
        chk("m_gnt", 256'(gnt), 256'(4'b0100));
        req = '0;
        tick();
        tick();
        chk("m_done", 256'(done), 256'(4'b0100));
        chk("m_sum", sum, {{8{16'h8000}}, {8{16'h0002}}});
        chk("m_ovfl", 256'(ovf_lanes), 256'(16'hff00));
        chk("m_ovf", 256'(ovf), 256'(1));
        tick();

        // Reset to bring ptr back to 0, then fairness over 20 cycles.
        rst = 1'b1;
        tick();
        chk("r_sum", sum, 256'(0));
        rst = 1'b0;
        req = '1;
        for (int k = 0; k < 20; k++) begin
            tick();
            op = (k / 4) % 4;
            if (k % 4 == 3) begin
                chk("f_gnt", 256'(gnt), 256'(0));
            end else begin
                chk("f_gnt", 256'(gnt), 256'(1 << op));
                chk("f_done", 256'(done),
                    (k % 4 == 2) ? 256'(1 << op) : 256'(0));
            end
        end
        req = '0;

        // Pointer skip: grant 1 leaves ptr at 2, so 3 beats 1.
        set_op(1, {16{16'h0002}}, {16{16'h0003}});
        set_op(3, {16{16'h1234}}, {16{16'h0101}});
        req = 4'b0010;
        tick();
        chk("p_gnt1", 256'(gnt), 256'(4'b0010));
        req = '0;
        tick();
        tick();
        tick();
        req = 4'b1010;
        tick();
        chk("p_first", 256'(gnt), 256'(4'b1000));
        req = 4'b0010;
        tick();
        tick();
        chk("p_done3", 256'(done), 256'(4'b1000));
        chk("p_sum3", sum, {16{16'h1335}});
        chk("p_ovf3", 256'(ovf), 256'(0));
        tick();
        tick();
        chk("p_second", 256'(gnt), 256'(4'b0010));
        req = '0;
        tick();
        tick();
        chk("p_done1", 256'(done), 256'(4'b0010));
        chk("p_sum1", sum, {16{16'h0005}});
        tick();

        // Abort while in HI.
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        chk("a_hi_gnt", 256'(gnt), 256'(4'b0001));
        rst = 1'b1;
        tick();
        chk("a_done", 256'(done), 256'(0));
        chk("a_sum", sum, 256'(0));
        chk("a_ovf", 256'(ovf), 256'(0));
        chk("a_gnt", 256'(gnt), 256'(0));
        chk("a_busy", 256'(busy), 256'(0));
        rst = 1'b0;
        req = 4'b1000;
        tick();
        chk("a_gnt3", 256'(gnt), 256'(4'b1000));
        req = '0;
        tick();
        chk("a_nodone", 256'(done), 256'(0));
        tick();
        chk("a_done3", 256'(done), 256'(4'b1000));
        chk("a_sum3", sum, {16{16'h1335}});
        tick();
        chk("a_idle", 256'(busy), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
